// File: rtl/cc_reg64_pkg.sv
// Shared definitions for the condition-code register: jXX/cmovXX condition
// encodings and the flag values held while reset is asserted.
package cc_reg64_pkg;

    localparam logic [3:0] C_ALWAYS = 4'd0;
    localparam logic [3:0] C_LE     = 4'd1;
    localparam logic [3:0] C_L      = 4'd2;
    localparam logic [3:0] C_E      = 4'd3;
    localparam logic [3:0] C_NE     = 4'd4;
    localparam logic [3:0] C_GE     = 4'd5;
    localparam logic [3:0] C_G      = 4'd6;

    localparam logic ZF_RST = 1'b1;
    localparam logic SF_RST = 1'b0;
    localparam logic OF_RST = 1'b0;

endpackage

// File: rtl/cc_reg64_if.sv
// Bus between the execute stage and the condition-code register: flag update
// request, condition query, and the registered flag/condition outputs.
interface cc_reg64_if #(
    parameter int WIDTH = 64
);
    logic signed [WIDTH-1:0] alu_result;
    logic                    alu_zf;
    logic                    alu_of;
    logic                    set_cc;
    logic                    stall;
    logic                    cancel;
    logic                    cond_req;
    logic [3:0]              ifun;
    logic                    zf;
    logic                    sf;
    logic                    of;
    logic                    cnd;
    logic                    cnd_valid;
    logic                    cond_err;

    modport master (
        output alu_result, alu_zf, alu_of, set_cc, stall, cancel, cond_req, ifun,
        input  zf, sf, of, cnd, cnd_valid, cond_err
    );

    modport slave (
        input  alu_result, alu_zf, alu_of, set_cc, stall, cancel, cond_req, ifun,
        output zf, sf, of, cnd, cnd_valid, cond_err
    );
endinterface

// File: rtl/cc_reg64_cond_eval.sv
// Combinational decode of a jXX/cmovXX condition code against the flags;
// undefined codes yield cnd=0 with err raised.
module cond_eval
    import cc_reg64_pkg::*;
(
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    input  logic [3:0] ifun,
    output logic       cnd,
    output logic       err
);

    logic lt;
    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        err = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = lt | zf;
            C_L:      cnd = lt;
            C_E:      cnd = zf;
            C_NE:     cnd = ~zf;
            C_GE:     cnd = ~lt;
            C_G:      cnd = ~lt & ~zf;
            default:  err = 1'b1;
        endcase
    end

endmodule

// File: rtl/cc_reg64.sv
// Condition-code register: holds ZF/SF/OF from the ALU and returns a
// registered condition result one cycle after each evaluation request.
module cc_reg64
    import cc_reg64_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    cc_reg64_if.slave  bus
);

    logic zf_p0, sf_p0, of_p0;
    logic cnd_p1, vld_p1, err_p1;
    logic eval_cnd, eval_err;
    logic unused_alu_lsbs;

    // Only the sign bit of the result feeds the flags.
    assign unused_alu_lsbs = ^bus.alu_result[WIDTH-2:0];

    // Evaluation sees the flags as they stand before the edge (no bypass).
    cond_eval u_cond_eval (
        .zf   (zf_p0),
        .sf   (sf_p0),
        .of   (of_p0),
        .ifun (bus.ifun),
        .cnd  (eval_cnd),
        .err  (eval_err)
    );

    // Stage p0: architectural flags; cancel outranks stall outranks set_cc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zf_p0 <= ZF_RST;
            sf_p0 <= SF_RST;
            of_p0 <= OF_RST;
        end else if (!bus.cancel && !bus.stall && bus.set_cc) begin
            zf_p0 <= bus.alu_zf;
            sf_p0 <= bus.alu_result[WIDTH-1];
            of_p0 <= bus.alu_of;
        end
    end

    // Stage p1: registered condition result, frozen only by stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnd_p1 <= 1'b0;
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else if (!bus.stall) begin
            cnd_p1 <= bus.cond_req & eval_cnd;
            vld_p1 <= bus.cond_req;
            err_p1 <= bus.cond_req & eval_err;
        end
    end

    assign bus.zf        = zf_p0;
    assign bus.sf        = sf_p0;
    assign bus.of        = of_p0;
    assign bus.cnd       = cnd_p1;
    assign bus.cnd_valid = vld_p1;
    assign bus.cond_err  = err_p1;

endmodule

// File: tb/tb_cc_reg64.sv
// Directed bench for cc_reg64; outputs packed as {zf,sf,of,cnd,cnd_valid,cond_err}.
module tb_cc_reg64;

    localparam int WIDTH = 64;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cc_reg64_if #(.WIDTH(WIDTH)) bus ();

    cc_reg64 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [5:0] outs();
        return {bus.zf, bus.sf, bus.of, bus.cnd, bus.cnd_valid, bus.cond_err};
    endfunction

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sc, input logic [WIDTH-1:0] res, input logic azf,
                         input logic aof, input logic cr, input logic [3:0] fn);
        bus.set_cc     = sc;
        bus.alu_result = res;
        bus.alu_zf     = azf;
        bus.alu_of     = aof;
        bus.cond_req   = cr;
        bus.ifun       = fn;
    endtask

    localparam logic [WIDTH-1:0] NEG = 64'h8000_0000_0000_0000;

    initial begin
        rst        = 1'b1;
        bus.stall  = 1'b0;
        bus.cancel = 1'b0;
        drive(0, '0, 0, 0, 0, 4'd0);
        #1;
        chk("reset_async", outs(), 6'b100_000);
        tick();
        tick();
        rst = 1'b0;

        // e from reset flags (zf=1)
        drive(0, '0, 0, 0, 1, 4'd3);
        tick();
        chk("e_after_reset", outs(), 6'b100_110);
        drive(0, '0, 0, 0, 0, 4'd0);
        tick();
        chk("idle_clears", outs(), 6'b100_000);

        // same-edge set_cc and cond_req: evaluation uses old zf, then back-to-back
        drive(1, '0, 0, 0, 1, 4'd3);
        tick();
        chk("same_edge_pre", outs(), 6'b000_110);
        drive(0, '0, 0, 0, 1, 4'd3);
        tick();
        chk("same_edge_post", outs(), 6'b000_010);
        drive(0, '0, 0, 0, 1, 4'd4);
        tick();
        chk("ne_b2b", outs(), 6'b000_110);

        // negative result: sf=1, of=0, zf=0
        drive(1, NEG, 0, 0, 0, 4'd0);
        tick();
        chk("load_sf", outs(), 6'b010_000);
        drive(0, '0, 0, 0, 1, 4'd2);
        tick();
        chk("l_true", outs(), 6'b010_110);
        drive(0, '0, 0, 0, 1, 4'd6);
        tick();
        chk("g_false", outs(), 6'b010_010);
        drive(0, '0, 0, 0, 1, 4'd1);
        tick();
        chk("le_true", outs(), 6'b010_110);
        drive(0, '0, 0, 0, 1, 4'd5);
        tick();
        chk("ge_false", outs(), 6'b010_010);

        // overflowed negative: sf=1, of=1 means not-less
        drive(1, NEG, 0, 1, 0, 4'd0);
        tick();
        chk("load_of", outs(), 6'b011_000);
        drive(0, '0, 0, 0, 1, 4'd2);
        tick();
        chk("l_of_false", outs(), 6'b011_010);
        drive(0, '0, 0, 0, 1, 4'd5);
        tick();
        chk("ge_of_true", outs(), 6'b011_110);
        drive(0, '0, 0, 0, 1, 4'd6);
        tick();
        chk("g_of_true", outs(), 6'b011_110);
        drive(0, '0, 0, 0, 1, 4'd0);
        tick();
        chk("always", outs(), 6'b011_110);

        // illegal condition codes
        drive(0, '0, 0, 0, 1, 4'd9);
        tick();
        chk("illegal_9", outs(), 6'b011_011);
        drive(0, '0, 0, 0, 0, 4'd0);
        tick();
        chk("illegal_idle", outs(), 6'b011_000);
        drive(0, '0, 0, 0, 1, 4'd7);
        tick();
        chk("illegal_7", outs(), 6'b011_011);
        drive(0, '0, 0, 0, 1, 4'd15);
        tick();
        chk("illegal_15", outs(), 6'b011_011);

        // restore zf=1, then cancel blocks the update but not the evaluation
        drive(1, '0, 1, 0, 0, 4'd0);
        tick();
        chk("load_zf1", outs(), 6'b100_000);
        bus.cancel = 1'b1;
        drive(1, NEG, 0, 1, 1, 4'd3);
        tick();
        chk("cancel_hold", outs(), 6'b100_110);
        bus.cancel = 1'b0;

        // stall freezes flags and the condition result
        drive(0, '0, 0, 0, 1, 4'd9);
        tick();
        chk("pre_stall", outs(), 6'b100_011);
        bus.stall = 1'b1;
        drive(1, NEG, 0, 1, 1, 4'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_%0d", i), outs(), 6'b100_011);
        end
        bus.stall = 1'b0;
        drive(0, '0, 0, 0, 0, 4'd0);
        tick();
        chk("post_stall", outs(), 6'b100_000);

        // reset mid-stream with cond_req held high
        drive(1, NEG, 0, 1, 1, 4'd0);
        tick();
        chk("pre_rst", outs(), 6'b011_110);
        drive(0, '0, 0, 0, 1, 4'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_mid", outs(), 6'b100_000);
        tick();
        chk("rst_held", outs(), 6'b100_000);
        rst = 1'b0;
        #1;
        chk("rst_fall", outs(), 6'b100_000);
        tick();
        chk("first_after_rst", outs(), 6'b100_110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cc_reg64.md
CC_REG64 -- requirements
Module: cc_reg64

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, the ALU result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port alu_result, input, WIDTH, the ALU result of the instruction offering a flag update.
REQ-005 The block SHALL have port alu_zf, input, 1, the zero flag from the selected ALU op unit (for example the 64-bit AND unit's zero flag).
REQ-006 The block SHALL have port alu_of, input, 1, the signed-overflow flag from the ALU (0 for logic ops).
REQ-007 The block SHALL have port set_cc, input, 1, a request to load the flags this cycle.
REQ-008 The block SHALL have port stall, input, 1, a pipeline stall that freezes all state.
REQ-009 The block SHALL have port cancel, input, 1, an exception in a later stage that suppresses the flag update.
REQ-010 The block SHALL have port cond_req, input, 1, a request to evaluate a condition.
REQ-011 The block SHALL have port ifun, input, 4, the condition code of a jXX/cmovXX instruction.
REQ-012 The block SHALL have ports zf, sf and of, each output, 1, the current flag register values.
REQ-013 The block SHALL have port cnd, output, 1, the registered condition result.
REQ-014 The block SHALL have port cnd_valid, output, 1, the qualifier for cnd.
REQ-015 The block SHALL have port cond_err, output, 1, set when an evaluated ifun is illegal.

Function
REQ-016 On a rising edge with set_cc=1, stall=0 and cancel=0, the block SHALL load zf<=alu_zf, sf<=alu_result[WIDTH-1] and of<=alu_of.
REQ-017 Priority SHALL be cancel > stall > set_cc: if cancel=1 the flags SHALL hold regardless of other inputs.
REQ-018 With stall=1, the flags, cnd, cnd_valid and cond_err SHALL all hold their values.
REQ-019 On an edge with cond_req=1 and stall=0, the block SHALL register cnd, set cnd_valid=1 and register cond_err; results appear one cycle after the request.
REQ-020 On an edge with cond_req=0 and stall=0, cnd_valid SHALL clear to 0, and cnd and cond_err SHALL clear to 0.
REQ-021 Evaluation SHALL use the flag values present before the edge; a set_cc on the same edge SHALL NOT affect that evaluation (no bypass).
REQ-022 The conditions SHALL be: ifun 0 gives 1 (always); 1 gives (sf^of)|zf (le); 2 gives sf^of (l); 3 gives zf (e); 4 gives !zf (ne); 5 gives !(sf^of) (ge); 6 gives !(sf^of)&!zf (g).
REQ-023 For ifun 7..15, cnd SHALL be 0 and cond_err SHALL be 1, with cnd_valid=1.
REQ-024 Back-to-back cond_req SHALL produce one result per cycle with no bubble.
REQ-025 cancel SHALL NOT suppress condition evaluation; only stall freezes it.

Reset
REQ-026 While rst=1, immediately and independent of clk, the block SHALL force zf=1, sf=0, of=0, cnd=0, cnd_valid=0 and cond_err=0.
REQ-027 A rst assertion during a pending evaluation SHALL discard that evaluation; the first valid result SHALL appear one cycle after the first cond_req sampled after reset deasserts.

Structure
REQ-028 A shared package SHALL hold the ifun constants (C_ALWAYS=0, C_LE=1, C_L=2, C_E=3, C_NE=4, C_GE=5, C_G=6) and the flag reset values (ZF_RST=1, SF_RST=0, OF_RST=0).
REQ-029 Condition decoding SHALL be one combinational sub-module, cond_eval (inputs zf, sf, of, ifun; outputs cnd, err), instantiated once.
REQ-030 All state SHALL reside in cc_reg64 and be clocked by clk only.

Verification
REQ-031 Reset then cond_req with ifun=3 -> next cycle cnd=1, cnd_valid=1 (reset zf=1).
REQ-032 set_cc with alu_result=0x8000_0000_0000_0000, alu_zf=0, alu_of=0, then ifun=2 -> sf=1, cnd=1; then ifun=6 -> cnd=0.
REQ-033 set_cc=1 and cancel=1 with alu_zf=0 -> zf stays 1; repeat with stall=1 and cancel=0 -> zf stays 1 and cnd/cnd_valid hold for the whole stall.
REQ-034 Same-edge set_cc (alu_zf=0) and cond_req ifun=3 from reset -> cnd=1 (pre-update); the following cond_req ifun=3 -> cnd=0.
REQ-035 cond_req with ifun=9 -> cnd=0, cond_err=1, cnd_valid=1; the next idle cycle -> cnd_valid=0, cond_err=0.
REQ-036 Assert rst mid-stream with cond_req held high -> all outputs reach reset values before the next edge, and the first cnd_valid appears one cycle after rst falls.
